vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between the display pixel fetch and the game-logic write port.
- Runs on the 50 MHz system clock. It is phase-locked to the 25 MHz pixel clock and the DrawX/DrawY counters of the VGA timing generator.
- The display fetch owns one Clk cycle per visible pixel. The game-logic writes, queued in a small FIFO, get every other slot.
- Sits between vga_controller, the sprite/playfield update logic and the VRAM macro.

---
 rtl/vram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch owns pixel_clk=1 slots inside the
// playfield window; queued game-logic writes get every other slot.
module vram_arbiter #(
  parameter int X0         = 161,
  parameter int Y0         = 61,
  parameter int WIDTH      = 318,
  parameter int HEIGHT     = 358,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BG_COLOR   = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pixel_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [10:0] XL = 11'(X0);
  localparam logic [10:0] XH = 11'(X0 + WIDTH);
  localparam logic [9:0]  YL = 10'(Y0);
  localparam logic [9:0]  YH = 10'(Y0 + HEIGHT);

  localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(WIDTH * HEIGHT);
  localparam logic [PW:0]       FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] BG   = DATA_W'(BG_COLOR);

  // Lookahead: fetch the pixel one to the right of the current DrawX
  logic [10:0]       nx;
  logic [10:0]       dx;
  logic [9:0]        dy;
  logic              in_win;
  logic              rd;
  logic [ADDR_W-1:0] rd_addr;

  assign nx     = {1'b0, DrawX} + 11'd1;
  assign dx     = nx - XL;
  assign dy     = DrawY - YL;
  assign in_win = (nx >= XL) && (nx < XH)
               && (DrawY >= YL) && (DrawY < YH);
  assign rd     = !Reset && pixel_clk && in_win;
  assign rd_addr =
    ADDR_W'(32'(dy) * 32'(WIDTH) + 32'(dx));

  logic [ADDR_W-1:0] fa_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fd_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW:0]       cnt_q;
  logic [PW:0]       cnt_d;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_ok;

  assign full      = (cnt_q == FULL);
  assign empty     = (cnt_q == '0);
  assign wr_ready  = !Reset && !full;
  assign push      = wr_valid && wr_ready;
  assign pop       = !Reset && !rd && !empty;
  assign head_addr = fa_q[rd_ptr_q];
  assign head_data = fd_q[rd_ptr_q];
  assign head_ok   = ({1'b0, head_addr} < LIM);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fa_q[wr_ptr_q] <= wr_addr;
      fd_q[wr_ptr_q] <= wr_data;
    end
  end

  // Memory port: address/data hold their last value on idle slots
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  always_comb begin
    mem_we    = 1'b0;
    wr_err    = 1'b0;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if (Reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (rd) begin
      mem_addr = rd_addr;
    end else if (pop) begin
      if (head_ok) begin
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end else begin
        wr_err = 1'b1;
      end
    end
  end

  logic              rd_pend_q;
  logic [DATA_W-1:0] pix_q;
  logic              pv_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_pend_q   <= 1'b0;
      pix_q       <= BG;
      pv_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rd_pend_q   <= rd;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
      // Capture lands on the edge that advances DrawX
      if (!pixel_clk) begin
        pix_q <= rd_pend_q ? mem_rdata : BG;
        pv_q  <= rd_pend_q;
      end
    end
  end

  assign pix_data  = pix_q;
  assign pix_valid = pv_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural VRAM model.
module tb_vram_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          pixel_clk;
  logic [9:0]    DrawX;
  logic [9:0]    DrawY;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pix_data;
  logic          pix_valid;

  vram_arbiter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .pixel_clk (pixel_clk),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid)
  );

  always #5 Clk = ~Clk;

  logic [7:0]    vram [0:131071];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge Clk) begin
    if (pre_we) vram[pre_addr] <= pre_data;
    else if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  int wq_addr[$];
  int wq_data[$];
  int wq_pc[$];

  always @(negedge Clk) begin
    if (mem_we === 1'b1) begin
      wq_addr.push_back(int'(mem_addr));
      wq_data.push_back(int'(mem_wdata));
      wq_pc.push_back(int'(pixel_clk));
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic drv(input logic pc, input int x, input int y);
    pixel_clk = pc;
    DrawX     = 10'(x);
    DrawY     = 10'(y);
  endtask

  task automatic preload(input int a, input int d);
    pre_we   = 1'b1;
    pre_addr = AW'(a);
    pre_data = DW'(d);
    nxt();
    pre_we   = 1'b0;
  endtask

  typedef struct {
    int x;
    int y;
    int rd;
    int addr;
    int cp;
    int pv;
    int pd;
  } vec_t;

  vec_t tv [14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int n;

    tv = '{
      '{159, 61,  0, 0,      1, 0, 'h00},
      '{160, 61,  1, 0,      1, 0, 'h00},
      '{161, 61,  1, 1,      1, 1, 'h5A},
      '{162, 61,  1, 2,      1, 1, 'hC3},
      '{163, 61,  1, 3,      1, 1, 'h77},
      '{476, 418, 1, 113842, 0, 0, 'h00},
      '{477, 418, 1, 113843, 1, 1, 'h11},
      '{478, 418, 0, 0,      1, 1, 'h99},
      '{479, 418, 0, 0,      1, 0, 'h00},
      '{200, 60,  0, 0,      1, 0, 'h00},
      '{200, 419, 0, 0,      1, 0, 'h00},
      '{799, 100, 0, 0,      1, 0, 'h00},
      '{160, 418, 1, 113526, 1, 0, 'h00},
      '{161, 418, 1, 113527, 1, 1, 'h42}
    };

    Reset    = 1'b1;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    drv(0, 0, 0);
    nxt();
    preload(0, 'h5A);
    preload(1, 'hC3);
    preload(2, 'h77);
    preload(113842, 'h11);
    preload(113843, 'h99);
    preload(113526, 'h42);

    @(negedge Clk);
    chk("rst_ready_low", wr_ready, 0);
    chk("rst_we", mem_we, 0);
    nxt();
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_ready", wr_ready, 1);
    chk("post_rst_pv", pix_valid, 0);
    chk("post_rst_pd", pix_data, 0);
    chk("post_rst_addr", mem_addr, 0);
    chk("post_rst_err", wr_err, 0);
    nxt();

    for (int i = 0; i < 10; i++) begin
      drv(1, i * 50, 0);
      @(negedge Clk);
      chk("idle_we_disp", mem_we, 0);
      nxt();
      drv(0, i * 50, 0);
      @(negedge Clk);
      chk("idle_we_wr", mem_we, 0);
      chk("idle_pv", pix_valid, 0);
      nxt();
    end

    for (int i = 0; i < 14; i++) begin
      drv(1, tv[i].x, tv[i].y);
      @(negedge Clk);
      if (tv[i].cp != 0) begin
        chk($sformatf("v%0d_pv", i), pix_valid, tv[i].pv);
        chk($sformatf("v%0d_pd", i), pix_data, tv[i].pd);
      end
      chk($sformatf("v%0d_we", i), mem_we, 0);
      if (tv[i].rd != 0)
        chk($sformatf("v%0d_addr", i), mem_addr, tv[i].addr);
      nxt();
      drv(0, tv[i].x, tv[i].y);
      @(negedge Clk);
      chk($sformatf("v%0d_we0", i), mem_we, 0);
      nxt();
    end

    // Fill the queue while display slots are held in-window
    base = wq_addr.size();
    drv(1, 250, 100);
    wr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_addr = AW'(10 + k);
      wr_data = DW'(1 + k);
      @(negedge Clk);
      chk("fill_ready", wr_ready, 1);
      nxt();
    end
    wr_addr = AW'(14);
    wr_data = DW'(5);
    @(negedge Clk);
    chk("full_ready", wr_ready, 0);
    chk("full_no_we", mem_we, 0);
    nxt();
    drv(0, 250, 100);
    @(negedge Clk);
    chk("full_pop_ready", wr_ready, 0);
    chk("full_pop_we", mem_we, 1);
    chk("full_pop_addr", mem_addr, 10);
    nxt();
    drv(1, 251, 100);
    @(negedge Clk);
    chk("push5_ready", wr_ready, 1);
    nxt();
    wr_valid = 1'b0;
    for (int p = 0; p < 6; p++) begin
      drv(0, 251 + p, 100);
      nxt();
      drv(1, 252 + p, 100);
      @(negedge Clk);
      chk("win_disp_no_we", mem_we, 0);
      nxt();
    end
    chk("seqA_count", wq_addr.size() - base, 5);
    for (int j = 0; j < 5; j++) begin
      if (base + j < wq_addr.size()) begin
        chk("seqA_addr", wq_addr[base + j], 10 + j);
        chk("seqA_data", wq_data[base + j], 1 + j);
        chk("seqA_slot", wq_pc[base + j], 0);
      end
      chk("seqA_vram", vram[10 + j], 1 + j);
    end

    // Blanking: both slots granted to writes
    drv(1, 600, 100);
    wr_valid = 1'b1;
    wr_addr  = AW'(20);
    wr_data  = 8'hA0;
    @(negedge Clk);
    chk("blk_c0_we", mem_we, 0);
    nxt();
    drv(0, 600, 100);
    wr_addr = AW'(21);
    wr_data = 8'hA1;
    @(negedge Clk);
    chk("blk_c1_we", mem_we, 1);
    chk("blk_c1_addr", mem_addr, 20);
    chk("blk_c1_data", mem_wdata, 'hA0);
    nxt();
    drv(1, 600, 100);
    wr_addr = AW'(22);
    wr_data = 8'hA2;
    @(negedge Clk);
    chk("blk_c2_we", mem_we, 1);
    chk("blk_c2_addr", mem_addr, 21);
    nxt();
    wr_valid = 1'b0;
    drv(0, 600, 100);
    @(negedge Clk);
    chk("blk_c3_we", mem_we, 1);
    chk("blk_c3_addr", mem_addr, 22);
    nxt();
    drv(1, 600, 100);
    @(negedge Clk);
    chk("blk_c4_we", mem_we, 0);
    chk("blk_c4_hold", mem_addr, 22);
    nxt();

    // Out-of-range drop followed by valid writes
    drv(0, 600, 100);
    wr_valid = 1'b1;
    wr_addr  = AW'(113844);
    wr_data  = 8'hEE;
    @(negedge Clk);
    chk("err_c0_err", wr_err, 0);
    nxt();
    drv(1, 600, 100);
    wr_addr = AW'(30);
    wr_data = 8'h33;
    @(negedge Clk);
    chk("err_c1_err", wr_err, 1);
    chk("err_c1_we", mem_we, 0);
    chk("err_c1_hold", mem_addr, 22);
    nxt();
    drv(0, 600, 100);
    wr_addr = AW'(113843);
    wr_data = 8'h44;
    @(negedge Clk);
    chk("err_c2_err", wr_err, 0);
    chk("err_c2_we", mem_we, 1);
    chk("err_c2_addr", mem_addr, 30);
    chk("err_c2_data", mem_wdata, 'h33);
    nxt();
    wr_valid = 1'b0;
    drv(1, 600, 100);
    @(negedge Clk);
    chk("err_c3_we", mem_we, 1);
    chk("err_c3_addr", mem_addr, 113843);
    chk("err_c3_err", wr_err, 0);
    nxt();
    drv(0, 600, 100);
    @(negedge Clk);
    chk("err_c4_we", mem_we, 0);
    nxt();

    // Reset with writes queued and a read capture pending
    drv(1, 250, 100);
    wr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_addr = AW'(40 + k);
      wr_data = DW'(8'h70 + k);
      nxt();
    end
    wr_valid = 1'b0;
    Reset = 1'b1;
    drv(0, 250, 100);
    @(negedge Clk);
    chk("rst2_ready", wr_ready, 0);
    chk("rst2_we", mem_we, 0);
    nxt();
    Reset = 1'b0;
    n = wq_addr.size();
    drv(1, 600, 100);
    @(negedge Clk);
    chk("rst2_ready_after", wr_ready, 1);
    chk("rst2_pv", pix_valid, 0);
    nxt();
    for (int c = 0; c < 8; c++) begin
      drv(logic'(c % 2 == 1), 600, 100);
      @(negedge Clk);
      chk("rst2_no_we", mem_we, 0);
      nxt();
    end
    chk("rst2_none_issued", wq_addr.size(), n);
    chk("rst2_vram40", vram[40] === 8'h70, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
